// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-client SPI master arbiter.
// Holds the FSM state encoding, requester IDs and the timeout poison word.
// Imported by spi_arb and spi_arb_req_buf.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic ID_INERT = 1'b0;
  localparam logic ID_A2D   = 1'b1;

  // Returned to the client in place of real data when the master never answers.
  localparam logic [15:0] TMO_POISON = 16'hDEAD;

endpackage

// File: rtl/spi_arb_req_buf.sv
// Per-client command buffer: one pending flag, one 16-bit command, sticky overrun.
// Latency: a request becomes visible as pend on the edge after the req pulse.
// No backpressure: a newer request overwrites an unserved one and flags ovrn.
module spi_arb_req_buf
  import spi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] cmd,
  input  logic        clr,
  output logic        pend,
  output logic [15:0] buf_cmd,
  output logic        ovrn
);

  // A request always wins over a same-cycle grant clear: the grant has already
  // taken the old command, so the new one stays pending and is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      buf_cmd <= '0;
      ovrn    <= 1'b0;
    end else if (req) begin
      pend    <= 1'b1;
      buf_cmd <= cmd;
      if (pend && !clr) ovrn <= 1'b1;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between the inertial and A2D clients.
// Latency: wrt rises two cycles after a req pulse on an idle arbiter; done_x one cycle after done.
// No backpressure: requests are buffered one deep; extra requests overwrite and set ovrn.
// Optional: define SPI_ARB_TMO_EN to abort a WAIT after TMO_CYCLES cycles with rd_x = 16'hDEAD.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_inert,
  input  logic [15:0] cmd_inert,
  output logic        done_inert,
  output logic [15:0] rd_inert,
  input  logic        req_a2d,
  input  logic [15:0] cmd_a2d,
  output logic        done_a2d,
  output logic [15:0] rd_a2d,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        sel,
  output logic        busy,
  output logic [1:0]  ovrn,
  output logic        tmo_err
);

  state_t      state, state_nxt;
  logic        last_gnt;
  logic        grant;
  logic        win;
  logic        capture;
  logic        tmo_hit;
  logic        pend_inert, pend_a2d;
  logic [15:0] buf_inert, buf_a2d;

  spi_arb_req_buf u_buf_inert (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_inert),
    .cmd     (cmd_inert),
    .clr     (grant && (win == ID_INERT)),
    .pend    (pend_inert),
    .buf_cmd (buf_inert),
    .ovrn    (ovrn[0])
  );

  spi_arb_req_buf u_buf_a2d (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_a2d),
    .cmd     (cmd_a2d),
    .clr     (grant && (win == ID_A2D)),
    .pend    (pend_a2d),
    .buf_cmd (buf_a2d),
    .ovrn    (ovrn[1])
  );

`ifdef SPI_ARB_TMO_EN
  logic [12:0] tmo_cnt;

  // Cycle count within WAIT; zeroed while launching so each transaction starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (state == LAUNCH)  tmo_cnt <= '0;
    else if (state == WAIT)    tmo_cnt <= tmo_cnt + 13'd1;
  end

  assign tmo_hit = (state == WAIT) && !done && (tmo_cnt == 13'(TMO_CYCLES - 1));
`else
  logic tmo_unused;
  assign tmo_unused = ^TMO_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and grant decision; with both pending the client not served last wins.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = ID_INERT;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_inert || pend_a2d) begin
          grant     = 1'b1;
          if (pend_inert && pend_a2d) win = ~last_gnt;
          else                        win = pend_a2d ? ID_A2D : ID_INERT;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant-time routing registers and response capture; sel/cmd move only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= ID_INERT;
      cmd      <= '0;
      last_gnt <= ID_A2D;
      rd_inert <= '0;
      rd_a2d   <= '0;
    end else begin
      if (grant) begin
        sel      <= win;
        cmd      <= (win == ID_A2D) ? buf_a2d : buf_inert;
        last_gnt <= win;
      end
      if (capture) begin
        if (sel == ID_A2D) rd_a2d   <= rd_data;
        else               rd_inert <= rd_data;
      end else if (tmo_hit) begin
        if (sel == ID_A2D) rd_a2d   <= TMO_POISON;
        else               rd_inert <= TMO_POISON;
      end
    end
  end

`ifdef SPI_ARB_TMO_EN
  // Sticky record that some transaction was abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tmo_err <= 1'b0;
    else if (tmo_hit) tmo_err <= 1'b1;
  end
`else
  assign tmo_err = 1'b0;
`endif

  assign wrt        = (state == LAUNCH);
  assign busy       = (state != IDLE);
  assign done_inert = (state == DONE) && (sel == ID_INERT);
  assign done_a2d   = (state == DONE) && (sel == ID_A2D);

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: single request, simultaneous requests, fairness,
// overrun, reset during WAIT and (with SPI_ARB_TMO_EN) timeout.
// Inputs driven and outputs sampled 1 time unit after the rising clock edge.
module tb_spi_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_inert = 1'b0;
  logic [15:0] cmd_inert = '0;
  logic        done_inert;
  logic [15:0] rd_inert;
  logic        req_a2d = 1'b0;
  logic [15:0] cmd_a2d = '0;
  logic        done_a2d;
  logic [15:0] rd_a2d;
  logic        wrt;
  logic [15:0] cmd;
  logic        done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        sel;
  logic        busy;
  logic [1:0]  ovrn;
  logic        tmo_err;

  int n_vec = 0;
  int n_err = 0;

  spi_arb #(.TMO_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_inert  (req_inert),
    .cmd_inert  (cmd_inert),
    .done_inert (done_inert),
    .rd_inert   (rd_inert),
    .req_a2d    (req_a2d),
    .cmd_a2d    (cmd_a2d),
    .done_a2d   (done_a2d),
    .rd_a2d     (rd_a2d),
    .wrt        (wrt),
    .cmd        (cmd),
    .done       (done),
    .rd_data    (rd_data),
    .sel        (sel),
    .busy       (busy),
    .ovrn       (ovrn),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_inert = 1'b0; req_a2d = 1'b0; done = 1'b0; rd_data = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_req(input logic who, input logic [15:0] c);
    if (who) begin req_a2d = 1'b1; cmd_a2d = c; end
    else     begin req_inert = 1'b1; cmd_inert = c; end
    step();
    req_inert = 1'b0;
    req_a2d   = 1'b0;
  endtask

  // Returns at the sample point of the LAUNCH cycle.
  task automatic wait_launch(input logic exp_sel, input logic [15:0] exp_cmd, input string tag);
    int n;
    n = 0;
    step();
    while (wrt !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_wrt"}, {31'd0, wrt}, 32'd1);
    check({tag, "_sel"}, {31'd0, sel}, {31'd0, exp_sel});
    check({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
  endtask

  // From LAUNCH: a few WAIT cycles, then done; returns at the DONE-cycle sample point.
  task automatic finish(input logic exp_sel, input logic [15:0] rdv, input string tag);
    step();
    step();
    step();
    check({tag, "_wrt_low"}, {31'd0, wrt}, 32'd0);
    check({tag, "_sel_hold"}, {31'd0, sel}, {31'd0, exp_sel});
    done = 1'b1;
    rd_data = rdv;
    step();
    done = 1'b0;
    rd_data = 16'hFFFF;
    check({tag, "_done_i"}, {31'd0, done_inert}, {31'd0, ~exp_sel});
    check({tag, "_done_a"}, {31'd0, done_a2d}, {31'd0, exp_sel});
    if (exp_sel) check({tag, "_rd_a"}, {16'd0, rd_a2d}, {16'd0, rdv});
    else         check({tag, "_rd_i"}, {16'd0, rd_inert}, {16'd0, rdv});
  endtask

  initial begin
    logic       acc;
    logic       who;
    logic [15:0] nc_i, nc_a;

    // ---- Reset values ----
    #1;
    check("rst_wrt", {31'd0, wrt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    do_reset();
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_ovrn", {30'd0, ovrn}, 32'd0);
    check("rst_tmo", {31'd0, tmo_err}, 32'd0);
    check("rst_done", {30'd0, done_a2d, done_inert}, 32'd0);
    check("rst_rd", {rd_a2d, rd_inert}, 32'd0);

    // ---- Single inertial request, exact timing ----
    req_inert = 1'b1; cmd_inert = 16'h8F00;
    step();
    req_inert = 1'b0;
    check("t1_wrt_c1", {31'd0, wrt}, 32'd0);
    check("t1_busy_c1", {31'd0, busy}, 32'd0);
    step();
    check("t1_wrt_c2", {31'd0, wrt}, 32'd1);
    check("t1_cmd", {16'd0, cmd}, 32'h0000_8F00);
    check("t1_sel", {31'd0, sel}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc = acc | done_a2d | done_inert | wrt;
    end
    check("t1_quiet_wait", {31'd0, acc}, 32'd0);
    done = 1'b1; rd_data = 16'h1234;
    step();
    done = 1'b0; rd_data = 16'h0000;
    check("t1_done_i", {31'd0, done_inert}, 32'd1);
    check("t1_done_a", {31'd0, done_a2d}, 32'd0);
    check("t1_rd_i", {16'd0, rd_inert}, 32'h0000_1234);
    step();
    check("t1_done_i_end", {31'd0, done_inert}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_rd_i_hold", {16'd0, rd_inert}, 32'h0000_1234);
    // done outside WAIT must be ignored
    done = 1'b1; rd_data = 16'h5555;
    step();
    done = 1'b0;
    step();
    check("t1_stray_done", {29'd0, busy, done_inert, done_a2d}, 32'd0);
    check("t1_stray_rd", {16'd0, rd_inert}, 32'h0000_1234);

    // ---- Simultaneous requests after reset ----
    do_reset();
    req_inert = 1'b1; cmd_inert = 16'hA001;
    req_a2d   = 1'b1; cmd_a2d   = 16'hB002;
    step();
    req_inert = 1'b0; req_a2d = 1'b0;
    wait_launch(1'b0, 16'hA001, "t2_first");
    finish(1'b0, 16'h0101, "t2_first");
    wait_launch(1'b1, 16'hB002, "t2_second");
    finish(1'b1, 16'h0202, "t2_second");
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      acc = acc | wrt | done_inert | done_a2d;
    end
    check("t2_no_extra", {31'd0, acc}, 32'd0);

    // ---- Round-robin fairness over 8 transactions ----
    do_reset();
    nc_i = 16'h1000; nc_a = 16'h2000;
    req_inert = 1'b1; cmd_inert = nc_i;
    req_a2d   = 1'b1; cmd_a2d   = nc_a;
    step();
    req_inert = 1'b0; req_a2d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      who = (i % 2 == 1);
      wait_launch(who, who ? nc_a : nc_i, $sformatf("rr%0d", i));
      finish(who, 16'h5000 + 16'(i), $sformatf("rr%0d", i));
      if (who) nc_a = nc_a + 16'd1;
      else     nc_i = nc_i + 16'd1;
      pulse_req(who, who ? nc_a : nc_i);
    end

    // ---- Overrun on the A2D buffer ----
    do_reset();
    pulse_req(1'b0, 16'h8F00);
    wait_launch(1'b0, 16'h8F00, "ov_inert");
    step();
    req_a2d = 1'b1; cmd_a2d = 16'h0800;
    step();
    cmd_a2d = 16'h0C00;
    step();
    req_a2d = 1'b0;
    check("ov_flag", {30'd0, ovrn}, 32'd2);
    check("ov_sel_hold", {31'd0, sel}, 32'd0);
    done = 1'b1; rd_data = 16'h1111;
    step();
    done = 1'b0;
    check("ov_done_i", {31'd0, done_inert}, 32'd1);
    check("ov_rd_i", {16'd0, rd_inert}, 32'h0000_1111);
    wait_launch(1'b1, 16'h0C00, "ov_a2d");
    finish(1'b1, 16'h2222, "ov_a2d");
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      acc = acc | wrt;
    end
    check("ov_single_a2d", {31'd0, acc}, 32'd0);
    check("ov_sticky", {30'd0, ovrn}, 32'd2);

    // ---- Reset while in WAIT ----
    pulse_req(1'b0, 16'h4242);
    wait_launch(1'b0, 16'h4242, "rw");
    step();
    pulse_req(1'b1, 16'h0101);
    rst_n = 1'b0;
    #1;
    check("rw_wrt", {31'd0, wrt}, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_sel", {31'd0, sel}, 32'd0);
    check("rw_cmd", {16'd0, cmd}, 32'd0);
    check("rw_ovrn", {30'd0, ovrn}, 32'd0);
    check("rw_rd", {rd_a2d, rd_inert}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    done = 1'b1; rd_data = 16'hBEEF;
    step();
    done = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      acc = acc | wrt | done_inert | done_a2d | busy;
    end
    check("rw_quiet", {31'd0, acc}, 32'd0);
    check("rw_rd_after", {rd_a2d, rd_inert}, 32'd0);
    pulse_req(1'b0, 16'h7777);
    wait_launch(1'b0, 16'h7777, "rw_next");
    finish(1'b0, 16'h3333, "rw_next");

`ifdef SPI_ARB_TMO_EN
    // ---- Timeout with TMO_CYCLES = 16 ----
    do_reset();
    pulse_req(1'b0, 16'h9999);
    wait_launch(1'b0, 16'h9999, "tmo");
    step();
    acc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      acc = acc | done_inert | tmo_err;
    end
    check("tmo_early", {31'd0, acc}, 32'd0);
    step();
    check("tmo_done_i", {31'd0, done_inert}, 32'd1);
    check("tmo_rd_i", {16'd0, rd_inert}, 32'h0000_DEAD);
    check("tmo_err", {31'd0, tmo_err}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
